// File: rtl/pc_sum.sv
// pc_sum: registered program-counter target adder for the RV32 fetch/branch path.
// Adds two XLEN-bit operands modulo 2^XLEN, optionally clears bit 0 (JALR),
// reports the unsigned carry-out and flags targets that break instruction alignment.
module pc_sum #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int unsigned         IALIGN   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            jalr,
    output logic [XLEN-1:0] newpc,
    output logic            out_valid,
    output logic            carry,
    output logic            misaligned
);

    localparam int unsigned SUM_W = XLEN + 1;

    logic [SUM_W-1:0] sum_c;
    logic [XLEN-1:0]  newpc_d,      newpc_q;
    logic             out_valid_d,  out_valid_q;
    logic             carry_d,      carry_q;
    logic             misaligned_d, misaligned_q;

    // Next-state: capture a new target on in_valid, otherwise hold the result.
    always_comb begin
        newpc_d      = newpc_q;
        carry_d      = carry_q;
        misaligned_d = misaligned_q;
        out_valid_d  = 1'b0;
        sum_c        = SUM_W'(op_a) + SUM_W'(op_b);

        if (in_valid) begin
            newpc_d = sum_c[XLEN-1:0];
            if (jalr) begin
                newpc_d[0] = 1'b0;
            end
            carry_d      = sum_c[XLEN];
            // Only 32-bit alignment can be violated; bit 0 is never set by a
            // legal target, so bit 1 alone decides.
            misaligned_d = (IALIGN == 32) ? newpc_d[1] : 1'b0;
            out_valid_d  = 1'b1;
        end
    end

    // Result registers; reset takes effect immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            newpc_q      <= RESET_PC;
            out_valid_q  <= 1'b0;
            carry_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            newpc_q      <= newpc_d;
            out_valid_q  <= out_valid_d;
            carry_q      <= carry_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign newpc      = newpc_q;
    assign out_valid  = out_valid_q;
    assign carry      = carry_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sum.sv
// tb_pc_sum: self-checking bench for pc_sum with directed and randomized stimulus.
module tb_pc_sum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        jalr;
    logic [31:0] newpc;
    logic        out_valid;
    logic        carry;
    logic        misaligned;

    int n_checks;
    int n_errors;

    // Reference model state: what the outputs should show right now.
    logic [31:0] exp_pc;
    logic        exp_ov;
    logic        exp_c;
    logic        exp_m;

    pc_sum #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .IALIGN   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .jalr       (jalr),
        .newpc      (newpc),
        .out_valid  (out_valid),
        .carry      (carry),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: arithmetic target computation from the address rules.
    task automatic model_step(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic j);
        logic [63:0] s;
        logic [31:0] pc;
        if (v) begin
            s  = 64'(a) + 64'(b);
            pc = 32'(s % 64'h1_0000_0000);
            if (j && (pc % 2 == 1)) pc = pc - 32'd1;
            exp_pc = pc;
            exp_c  = (s >= 64'h1_0000_0000);
            exp_m  = ((pc % 4) >= 2);
            exp_ov = 1'b1;
        end else begin
            exp_ov = 1'b0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic j);
        @(negedge clk);
        in_valid = v;
        op_a     = a;
        op_b     = b;
        jalr     = j;
        @(posedge clk);
        #1;
        model_step(v, a, b, j);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, carry, misaligned, newpc} !== {3'b000, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_initial: got ov=%b c=%b m=%b pc=%h, want ov=0 c=0 m=0 pc=00000000",
                     out_valid, carry, misaligned, newpc);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0; exp_ov = 1'b0; exp_c = 1'b0; exp_m = 1'b0;
        // Load a non-reset value, then reset asynchronously between edges.
        drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0004, 1'b0);
        n_checks++;
        if ({out_valid, carry, newpc} !== {2'b11, 32'h0000_0002}) begin
            n_errors++;
            $display("FAIL reset_preload: got ov=%b c=%b pc=%h, want ov=1 c=1 pc=00000002",
                     out_valid, carry, newpc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, carry, misaligned, newpc} !== {3'b000, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_async: got ov=%b c=%b m=%b pc=%h, want ov=0 c=0 m=0 pc=00000000",
                     out_valid, carry, misaligned, newpc);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0; exp_ov = 1'b0; exp_c = 1'b0; exp_m = 1'b0;
        drive(1'b1, 32'h0000_0100, 32'h0000_0004, 1'b0);
        n_checks++;
        if ({out_valid, newpc} !== {1'b1, 32'h0000_0104}) begin
            n_errors++;
            $display("FAIL reset_first_result: got ov=%b pc=%h, want ov=1 pc=00000104",
                     out_valid, newpc);
        end
    endtask

    task automatic test_zero();
        drive(1'b1, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if ({out_valid, carry, misaligned, newpc} !== {3'b100, 32'h0}) begin
            n_errors++;
            $display("FAIL zero_add: got ov=%b c=%b m=%b pc=%h, want ov=1 c=0 m=0 pc=00000000",
                     out_valid, carry, misaligned, newpc);
        end
    endtask

    task automatic test_patterns();
        drive(1'b1, 32'h5555_5555, 32'h5555_5555, 1'b0);
        n_checks++;
        if ({carry, misaligned, newpc} !== {2'b01, 32'hAAAA_AAAA}) begin
            n_errors++;
            $display("FAIL pat_55_55: got c=%b m=%b pc=%h, want c=0 m=1 pc=aaaaaaaa",
                     carry, misaligned, newpc);
        end
        drive(1'b1, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        n_checks++;
        if ({carry, newpc} !== {1'b0, 32'hFFFF_FFFF}) begin
            n_errors++;
            $display("FAIL pat_55_aa: got c=%b pc=%h, want c=0 pc=ffffffff", carry, newpc);
        end
        drive(1'b1, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
        n_checks++;
        if ({carry, newpc} !== {1'b0, 32'hFFFF_FFFE}) begin
            n_errors++;
            $display("FAIL pat_jalr: got c=%b pc=%h, want c=0 pc=fffffffe", carry, newpc);
        end
        drive(1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
        n_checks++;
        if ({carry, misaligned, newpc} !== {2'b10, 32'h5555_5554}) begin
            n_errors++;
            $display("FAIL pat_aa_aa: got c=%b m=%b pc=%h, want c=1 m=0 pc=55555554",
                     carry, misaligned, newpc);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'h4, 1'b0);
            n_checks++;
            if ({out_valid, misaligned, newpc} !== {2'b10, 32'((i + 1) * 4)}) begin
                n_errors++;
                $display("FAIL b2b_%0d: got ov=%b m=%b pc=%h, want ov=1 m=0 pc=%h",
                         i, out_valid, misaligned, newpc, 32'((i + 1) * 4));
            end
        end
        drive(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        n_checks++;
        if ({out_valid, newpc} !== {1'b0, 32'h0000_0010}) begin
            n_errors++;
            $display("FAIL b2b_hold: got ov=%b pc=%h, want ov=0 pc=00000010", out_valid, newpc);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic        j;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            j = $urandom_range(0, 1) == 1;
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       b = 32'h4;
                1:       b = 32'($signed(12'($urandom)));
                default: b = $urandom;
            endcase
            drive(v, a, b, j);
            n_checks++;
            if ({out_valid, carry, misaligned, newpc} !== {exp_ov, exp_c, exp_m, exp_pc}) begin
                n_errors++;
                $display("FAIL rand_%0d: a=%h b=%h v=%b j=%b got ov=%b c=%b m=%b pc=%h, want ov=%b c=%b m=%b pc=%h",
                         i, a, b, v, j, out_valid, carry, misaligned, newpc,
                         exp_ov, exp_c, exp_m, exp_pc);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op_a     = 32'h0;
        op_b     = 32'h0;
        jalr     = 1'b0;
        exp_pc   = 32'h0;
        exp_ov   = 1'b0;
        exp_c    = 1'b0;
        exp_m    = 1'b0;

        test_reset();
        test_zero();
        test_patterns();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
